// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pulls characters from a TX FIFO and frames them as
// start / data / parity / stop bits, each bit timed by 16 pulses of baud_tick.
module uart_tx_serializer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           baud_tick,
  input  logic [1:0]     wls,
  input  logic           stb,
  input  logic           pen,
  input  logic           eps,
  input  logic           sp,
  input  logic           brk,
  input  logic           fifo_rempty,
  input  logic [WIDTH:0] fifo_data,
  output logic           fifo_read,
  output logic           txd,
  output logic           temt
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t           r_state, w_state_n;
  logic [3:0]       r_tick, w_tick_n;
  logic [2:0]       r_bit, w_bit_n;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_wls;
  logic             r_stb, r_pen, r_eps, r_sp;
  logic             r_txd, r_temt;

  logic             w_bit_end, w_half_end, w_last_data, w_last_stop;
  logic             w_par, w_txd_n, w_rd;
  logic [2:0]       w_nhalf;
  logic [WIDTH-1:0] w_mask;
  logic             w_unused_msb;

  assign w_unused_msb = fifo_data[WIDTH];

  assign w_bit_end   = baud_tick && (r_tick == 4'd15);
  assign w_half_end  = baud_tick && (r_tick[2:0] == 3'd7);
  assign w_last_data = (r_bit == (3'd4 + {1'b0, r_wls}));
  // r_bit doubles as a half-bit counter in STOP: 2, 3 or 4 halves
  assign w_nhalf     = !r_stb ? 3'd2 : ((r_wls == 2'b00) ? 3'd3 : 3'd4);
  assign w_last_stop = ((r_bit + 3'd1) == w_nhalf);

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++) w_mask[i] = (i < 5 + int'(r_wls));
  end

  assign w_par = r_sp ? ~r_eps : ((^(r_data & w_mask)) ^ ~r_eps);

  always_comb begin
    w_state_n = r_state;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_rd      = 1'b0;
    case (r_state)
      IDLE: if (!fifo_rempty) begin
        w_rd      = 1'b1;
        w_state_n = FETCH;
      end
      FETCH: w_state_n = LOAD;
      LOAD: begin
        w_state_n = START;
        w_tick_n  = 4'd0;
        w_bit_n   = 3'd0;
      end
      START: begin
        if (baud_tick) w_tick_n = r_tick + 4'd1;
        if (w_bit_end) w_state_n = DATA;
      end
      DATA: begin
        if (baud_tick) w_tick_n = r_tick + 4'd1;
        if (w_bit_end) begin
          if (w_last_data) begin
            w_state_n = r_pen ? PARITY : STOP;
            w_bit_n   = 3'd0;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) w_tick_n = r_tick + 4'd1;
        if (w_bit_end) w_state_n = STOP;
      end
      STOP: begin
        if (baud_tick) w_tick_n = r_tick + 4'd1;
        if (w_half_end) begin
          if (w_last_stop) begin
            w_bit_n  = 3'd0;
            w_tick_n = 4'd0;
            if (!fifo_rempty) begin
              w_rd      = 1'b1;
              w_state_n = FETCH;
            end else begin
              w_state_n = IDLE;
            end
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  // txd is registered from the next state so the line changes on the same edge as the FSM
  always_comb begin
    w_txd_n = 1'b1;
    case (w_state_n)
      START:   w_txd_n = 1'b0;
      DATA:    w_txd_n = r_data[w_bit_n];
      PARITY:  w_txd_n = w_par;
      default: w_txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_wls   <= '0;
      r_stb   <= 1'b0;
      r_pen   <= 1'b0;
      r_eps   <= 1'b0;
      r_sp    <= 1'b0;
      r_txd   <= 1'b1;
      r_temt  <= fifo_rempty;
    end else begin
      r_state <= w_state_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      if (r_state == LOAD) begin
        r_data <= fifo_data[WIDTH-1:0];
        r_wls  <= wls;
        r_stb  <= stb;
        r_pen  <= pen;
        r_eps  <= eps;
        r_sp   <= sp;
      end
      r_txd  <= brk ? 1'b0 : w_txd_n;
      r_temt <= (w_state_n == IDLE) && fifo_rempty;
    end
  end

  assign fifo_read = w_rd & rstn;
  assign txd       = r_txd;
  assign temt      = r_temt;

endmodule

// File: doc/uart_tx_serializer.md
UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the character data width; the FIFO word is WIDTH+1 bits.
REQ-002 SHALL have port clk, input, 1 bit: ARM clock; the single clock of the block.
REQ-003 SHALL have port rstn, input, 1 bit: ARM reset, synchronous, active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port baud_tick, input, 1 bit: one-clk pulse at 16x the baud rate.
REQ-005 SHALL have port wls, input, 2 bits: word length select (00=5, 01=6, 10=7, 11=8 data bits).
REQ-006 SHALL have port stb, input, 1 bit: stop bits select (0=1 stop; 1=1.5 stop at 5 data bits, else 2 stop).
REQ-007 SHALL have ports pen, eps and sp, input, 1 bit each: parity enable, even parity select and stick parity.
REQ-008 SHALL have port brk, input, 1 bit: break control.
REQ-009 SHALL have port fifo_rempty, input, 1 bit: TX FIFO empty flag.
REQ-010 SHALL have port fifo_data, input, WIDTH+1 bits: TX FIFO output word; only bits [WIDTH-1:0] are used.
REQ-011 SHALL have port fifo_read, output, 1 bit: TX FIFO read strobe.
REQ-012 SHALL have port txd, output, 1 bit: serial output line.
REQ-013 SHALL have port temt, output, 1 bit: transmitter empty (FIFO empty and shifter idle).

Function
REQ-014 SHALL implement the states IDLE, FETCH, LOAD, START, DATA, PARITY and STOP.
REQ-015 IDLE: if fifo_rempty=0, SHALL assert fifo_read for exactly one clk and go to FETCH; otherwise SHALL stay in IDLE.
REQ-016 FETCH: SHALL wait one clk, because the FIFO registers its output one clk after the read strobe, then go to LOAD.
REQ-017 LOAD: SHALL latch fifo_data[WIDTH-1:0], wls, stb, pen, eps and sp into internal registers; a change on these inputs mid-character SHALL NOT affect the current character.
REQ-018 After LOAD, SHALL go to START and clear the tick counter.
REQ-019 Each bit period SHALL be 16 baud_tick pulses, counted by a 4-bit tick counter that advances only on baud_tick.
REQ-020 START: SHALL drive txd=0 for 16 ticks.
REQ-021 DATA: SHALL send the data bits LSB first, with the bit count given by the latched wls; higher bits SHALL be ignored.
REQ-022 PARITY: SHALL be entered only if pen=1 and SHALL last 16 ticks.
REQ-023 Parity bit value:
- sp=0: parity bit = XOR of the sent bits, inverted when eps=0 (odd parity).
- sp=1: parity bit = ~eps.
REQ-024 STOP: SHALL drive txd=1 for 16 ticks (1 stop), 24 ticks (1.5 stop) or 32 ticks (2 stop).
REQ-025 At the end of STOP: if fifo_rempty=0, SHALL assert fifo_read in that same clk and go to FETCH (back-to-back characters with no idle gap); otherwise SHALL go to IDLE.
REQ-026 SHALL drive txd=1 in IDLE, FETCH and LOAD, except while brk is active.
REQ-027 When brk=1, txd SHALL be 0 regardless of state; the state machine SHALL continue unaffected.
REQ-028 temt SHALL be 1 only when in IDLE and fifo_rempty=1; temt and txd SHALL be registered.
REQ-029 fifo_read SHALL never be asserted while fifo_rempty=1 or while a read is already outstanding (in FETCH or LOAD).
REQ-030 A baud_tick arriving in IDLE, FETCH or LOAD SHALL be ignored.
REQ-031 The tick counter SHALL wrap 15->0 at each bit boundary; in 1.5/2-stop mode, the STOP length SHALL be tracked by a bit/half-bit counter.

Reset
REQ-032 While rstn=0 at a rising clk edge, outputs SHALL be txd=1, fifo_read=0 and temt=fifo_rempty, the state SHALL be IDLE, and all counters and latched registers SHALL be 0.
REQ-033 A reset asserted mid-character SHALL abort the character, return txd to 1 on the next edge and perform no fifo_read.
REQ-034 The first fifo_read after reset release SHALL occur no earlier than the first clk after rstn=1.

Verification
REQ-035 wls=11, pen=0, stb=0, FIFO holds 0x55 -> txd: 0, then 1,0,1,0,1,0,1,0, then 1, with each bit 16 ticks (160 ticks total); one fifo_read; temt=1 after STOP.
REQ-036 wls=00, pen=1, eps=1, stb=1, data 0x1F -> txd: 0, then 1,1,1,1,1, then parity 1, then stop high for 24 ticks.
REQ-037 Two words 0xA5 and 0x3C in the FIFO -> two fifo_read pulses; the second START bit begins within 3 clk after the first STOP ends; txd never returns to idle-high between the characters except during the stop bits.
REQ-038 sp=1, eps=0, pen=1, wls=10, data 0x00 -> parity bit = 1; with eps=1 -> parity bit = 0.
REQ-039 brk=1 asserted in the middle of the DATA state -> txd=0 at once; with brk=0 the character completes on its original timing; temt behaves as normal.
REQ-040 rstn=0 pulsed during the DATA state -> next clk: txd=1, state IDLE; with the FIFO non-empty, a new fifo_read occurs after release and the full character is sent from its start.
